// File: rtl/buzzer_seq_ctrl_if.sv
// Request/tone bus between the game FSM (master) and the buzzer sequencer (slave).
// req is a level request and grant a one-cycle acceptance pulse; there is no ready/back-pressure.
interface buzzer_seq_ctrl_if;
    logic [2:0]  req;
    logic        stop;
    logic        tone_en;
    logic [31:0] tone_div;
    logic        busy;
    logic [2:0]  grant;
    logic        done;
    logic [1:0]  active_id;

    modport master (
        output req, stop,
        input  tone_en, tone_div, busy, grant, done, active_id
    );
    modport slave (
        input  req, stop,
        output tone_en, tone_div, busy, grant, done, active_id
    );
endinterface

// File: rtl/buzzer_seq_ctrl.sv
// Buzzer melody sequencer: arbitrates spin/lose/win requests and plays timed notes with gaps.
// Optional melody preemption by a higher-priority request is built when SEQ_PREEMPT_EN is defined.
module buzzer_seq_ctrl #(
    parameter logic [31:0] NOTE_TICKS = 32'd7_500_000,
    parameter logic [31:0] GAP_TICKS  = 32'd500_000
) (
    input  logic              clk,
    input  logic              rst,
    buzzer_seq_ctrl_if.slave  bus,
    output logic [1:0]        o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t      r_state, w_state;
    logic [31:0] r_timer, w_timer;
    logic [1:0]  r_idx, w_idx;
    logic [1:0]  r_id, w_id;
    logic        r_tone_en, w_tone_en;
    logic [31:0] r_tone_div, w_tone_div;
    logic        r_busy, w_busy;
    logic [2:0]  r_grant, w_grant;
    logic        r_done, w_done;

    logic        w_any;
    logic [1:0]  w_win_id;
    logic        w_preempt;
    logic [1:0]  w_next_idx;
    logic        w_start;
    logic        w_clear;

    function automatic logic [31:0] note_div(input logic [1:0] id, input logic [1:0] idx);
        case ({id, idx})
            4'b00_00: return 32'd6250;
            4'b01_00: return 32'd41666;
            4'b01_01: return 32'd55555;
            4'b10_00: return 32'd38220;
            4'b10_01: return 32'd30337;
            4'b10_10: return 32'd25510;
            4'b10_11: return 32'd19110;
            default:  return 32'd0;
        endcase
    endfunction

    function automatic logic [2:0] note_len(input logic [1:0] id, input logic [1:0] idx);
        case ({id, idx})
            4'b00_00: return 3'd1;
            4'b01_00: return 3'd2;
            4'b01_01: return 3'd4;
            4'b10_11: return 3'd2;
            default:  return 3'd1;
        endcase
    endfunction

    function automatic logic [1:0] last_idx(input logic [1:0] id);
        case (id)
            2'd1:    return 2'd1;
            2'd2:    return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    // Timer counts down to zero, so a note of N clocks is loaded with N-1.
    function automatic logic [31:0] play_ticks(input logic [1:0] id, input logic [1:0] idx);
        return 32'(note_len(id, idx)) * NOTE_TICKS - 32'd1;
    endfunction

    assign w_any      = |bus.req;
    assign w_win_id   = bus.req[2] ? 2'd2 : (bus.req[1] ? 2'd1 : 2'd0);
    assign w_next_idx = r_idx + 2'd1;

`ifdef SEQ_PREEMPT_EN
    assign w_preempt = w_any && (w_win_id > r_id);
`else
    assign w_preempt = 1'b0;
`endif

    always_comb begin
        w_state    = r_state;
        w_timer    = r_timer;
        w_idx      = r_idx;
        w_id       = r_id;
        w_tone_en  = r_tone_en;
        w_tone_div = r_tone_div;
        w_busy     = r_busy;
        w_grant    = 3'b000;
        w_done     = 1'b0;
        w_start    = 1'b0;
        w_clear    = 1'b0;

        case (r_state)
            S_IDLE: w_start = !bus.stop && w_any;
            S_PLAY, S_GAP: begin
                if (bus.stop) begin
                    w_clear = 1'b1;
                end else if (w_preempt) begin
                    w_start = 1'b1;
                end else if (r_timer != 32'd0) begin
                    w_timer = r_timer - 32'd1;
                end else if (r_state == S_PLAY && r_idx == last_idx(r_id)) begin
                    w_clear = 1'b1;
                    w_done  = 1'b1;
                end else if (r_state == S_PLAY && GAP_TICKS != 32'd0) begin
                    w_state   = S_GAP;
                    w_timer   = GAP_TICKS - 32'd1;
                    w_tone_en = 1'b0;
                end else begin
                    w_state    = S_PLAY;
                    w_idx      = w_next_idx;
                    w_timer    = play_ticks(r_id, w_next_idx);
                    w_tone_en  = 1'b1;
                    w_tone_div = note_div(r_id, w_next_idx);
                end
            end
            default: w_clear = 1'b1;
        endcase

        if (w_clear) begin
            w_state    = S_IDLE;
            w_timer    = 32'd0;
            w_idx      = 2'd0;
            w_id       = 2'd0;
            w_tone_en  = 1'b0;
            w_tone_div = 32'd0;
            w_busy     = 1'b0;
        end

        if (w_start) begin
            w_state    = S_PLAY;
            w_timer    = play_ticks(w_win_id, 2'd0);
            w_idx      = 2'd0;
            w_id       = w_win_id;
            w_tone_en  = 1'b1;
            w_tone_div = note_div(w_win_id, 2'd0);
            w_busy     = 1'b1;
            w_grant    = 3'b001 << w_win_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_timer    <= 32'd0;
            r_idx      <= 2'd0;
            r_id       <= 2'd0;
            r_tone_en  <= 1'b0;
            r_tone_div <= 32'd0;
            r_busy     <= 1'b0;
            r_grant    <= 3'b000;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_timer    <= w_timer;
            r_idx      <= w_idx;
            r_id       <= w_id;
            r_tone_en  <= w_tone_en;
            r_tone_div <= w_tone_div;
            r_busy     <= w_busy;
            r_grant    <= w_grant;
            r_done     <= w_done;
        end
    end

    assign bus.tone_en   = r_tone_en;
    assign bus.tone_div  = r_tone_div;
    assign bus.busy      = r_busy;
    assign bus.grant     = r_grant;
    assign bus.done      = r_done;
    assign bus.active_id = r_id;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_buzzer_seq_ctrl.sv
// Bench for buzzer_seq_ctrl: table-driven melody checks, directed corner sequences, and
// random traffic compared each cycle against a timeline-based reference model.
module tb_buzzer_seq_ctrl;
    localparam int NT = 4;
    localparam int GT = 2;
    typedef logic [39:0] vec_t;

`ifdef SEQ_PREEMPT_EN
    localparam bit PREEMPT = 1'b1;
`else
    localparam bit PREEMPT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    buzzer_seq_ctrl_if bus_a();
    buzzer_seq_ctrl_if bus_b();
    logic [1:0] dbg_a, dbg_b;

    buzzer_seq_ctrl #(.NOTE_TICKS(32'd4), .GAP_TICKS(32'd2)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a), .o_dbg_state(dbg_a)
    );
    buzzer_seq_ctrl #(.NOTE_TICKS(32'd4), .GAP_TICKS(32'd0)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b), .o_dbg_state(dbg_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Melody table as written in the sound design: divider and length per note.
    int div_tab [3][4] = '{'{6250, 0, 0, 0}, '{41666, 55555, 0, 0}, '{38220, 30337, 25510, 19110}};
    int len_tab [3][4] = '{'{1, 0, 0, 0}, '{2, 4, 0, 0}, '{1, 1, 1, 2}};
    int cnt_tab [3]    = '{1, 2, 4};

    // Reference model: a melody is expanded into its full per-cycle output timeline.
    vec_t exp_q[$];
    vec_t m_out = '0;
    int   m_id  = 0;

    function automatic vec_t pack(input bit en, input int div, input bit busy,
                                  input logic [2:0] grant, input bit done, input int id);
        vec_t v;
        v = {en, 32'(div), busy, grant, done, 2'(id)};
        return v;
    endfunction

    task model_start(input int id);
        exp_q.delete();
        for (int n = 0; n < cnt_tab[id]; n++) begin
            repeat (len_tab[id][n] * NT) exp_q.push_back(pack(1'b1, div_tab[id][n], 1'b1, 3'b000, 1'b0, id));
            if (n < cnt_tab[id] - 1)
                repeat (GT) exp_q.push_back(pack(1'b0, div_tab[id][n], 1'b1, 3'b000, 1'b0, id));
        end
        exp_q.push_back(pack(1'b0, 0, 1'b0, 3'b000, 1'b1, 0));
        m_out = exp_q.pop_front();
        m_out[5:3] = 3'(1 << id);
        m_id = id;
    endtask

    task model_step(input logic [2:0] r, input logic s, input logic x);
        int top;
        top = r[2] ? 2 : (r[1] ? 1 : 0);
        if (x) begin
            exp_q.delete();
            m_out = '0;
        end else if (exp_q.size() != 0) begin
            if (s) begin
                exp_q.delete();
                m_out = '0;
            end else if (PREEMPT && r != 3'b000 && top > m_id) begin
                model_start(top);
            end else begin
                m_out = exp_q.pop_front();
            end
        end else if (!s && r != 3'b000) begin
            model_start(top);
        end else begin
            m_out = '0;
        end
    endtask

    vec_t dut_vec, vec_b;
    assign dut_vec = {bus_a.tone_en, bus_a.tone_div, bus_a.busy, bus_a.grant, bus_a.done, bus_a.active_id};
    assign vec_b   = {bus_b.tone_en, bus_b.tone_div, bus_b.busy, bus_b.grant, bus_b.done, bus_b.active_id};

    always @(posedge clk) model_step(bus_a.req, bus_a.stop, rst);
    always @(negedge clk) check("model", dut_vec, m_out);

    task automatic wait_done(output int lat);
        lat = 0;
        while (bus_a.done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic wait_grant(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (bus_a.grant === 3'b000 && lat < 100);
    endtask

    task automatic count_done(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (bus_a.done === 1'b1) n++;
        end
    endtask

    typedef struct {
        logic [2:0] req;
        logic [2:0] grant;
        logic [1:0] id;
        int         lat;
    } row_t;

    row_t rows [7];
    int   lat;
    int   nd;

    initial begin
        rows[0] = '{3'b001, 3'b001, 2'd0, 4};
        rows[1] = '{3'b010, 3'b010, 2'd1, 26};
        rows[2] = '{3'b100, 3'b100, 2'd2, 26};
        rows[3] = '{3'b011, 3'b010, 2'd1, 26};
        rows[4] = '{3'b101, 3'b100, 2'd2, 26};
        rows[5] = '{3'b110, 3'b100, 2'd2, 26};
        rows[6] = '{3'b111, 3'b100, 2'd2, 26};

        bus_a.req = 3'b000; bus_a.stop = 1'b0;
        bus_b.req = 3'b000; bus_b.stop = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_state_a", dut_vec, '0);
        check("reset_state_b", vec_b, '0);
        rst = 1'b0;
        @(negedge clk);

        // One pulse per row: grant, ID, first divider and done latency.
        for (int i = 0; i < 7; i++) begin
            bus_a.req = rows[i].req;
            @(negedge clk);
            bus_a.req = 3'b000;
            check("tbl_grant", bus_a.grant, rows[i].grant);
            check("tbl_id", bus_a.active_id, rows[i].id);
            check("tbl_div0", bus_a.tone_div, div_tab[rows[i].id][0]);
            wait_done(lat);
            check("tbl_done_lat", lat, rows[i].lat);
            @(negedge clk);
        end

        // Held 111: win granted, then regranted right after its done cycle.
        bus_a.req = 3'b111;
        @(negedge clk);
        check("held_grant1", bus_a.grant, 3'b100);
        check("held_id", bus_a.active_id, 2'd2);
        wait_grant(lat);
        bus_a.req = 3'b000;
        check("held_regrant_lat", lat, 27);
        check("held_grant2", bus_a.grant, 3'b100);
        wait_done(lat);
        check("held_done2_lat", lat, 26);
        @(negedge clk);

        // Lose playing, win requested while busy.
        bus_a.req = 3'b010;
        @(negedge clk);
        bus_a.req = 3'b000;
        check("busy_grant_lose", bus_a.grant, 3'b010);
        repeat (2) @(negedge clk);
        bus_a.req = 3'b100;
        @(negedge clk);
        bus_a.req = 3'b000;
`ifdef SEQ_PREEMPT_EN
        check("preempt_grant", bus_a.grant, 3'b100);
        check("preempt_div", bus_a.tone_div, 38220);
        check("preempt_id", bus_a.active_id, 2'd2);
        wait_done(lat);
        check("preempt_done_lat", lat, 26);
`else
        check("busy_ignore_grant", bus_a.grant, 3'b000);
        check("busy_ignore_div", bus_a.tone_div, 41666);
        check("busy_ignore_id", bus_a.active_id, 2'd1);
        wait_done(lat);
        check("busy_ignore_done_lat", lat, 23);
`endif
        @(negedge clk);

        // Stop on the third cycle of the first note.
        bus_a.req = 3'b100;
        @(negedge clk);
        bus_a.req = 3'b000;
        repeat (2) @(negedge clk);
        bus_a.stop = 1'b1;
        @(negedge clk);
        bus_a.stop = 1'b0;
        check("stop_tone_en", bus_a.tone_en, 1'b0);
        check("stop_busy", bus_a.busy, 1'b0);
        check("stop_div", bus_a.tone_div, 0);
        check("stop_done", bus_a.done, 1'b0);
        count_done(30, nd);
        check("stop_no_done", nd, 0);

        // Stop in idle swallows a simultaneous request.
        bus_a.req = 3'b001;
        bus_a.stop = 1'b1;
        @(negedge clk);
        bus_a.req = 3'b000;
        bus_a.stop = 1'b0;
        check("idle_stop_grant", bus_a.grant, 3'b000);
        check("idle_stop_busy", bus_a.busy, 1'b0);
        @(negedge clk);
        check("idle_stop_not_latched", bus_a.busy, 1'b0);

        // Reset held for three cycles in the middle of a melody.
        bus_a.req = 3'b010;
        @(negedge clk);
        bus_a.req = 3'b000;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_first_edge", dut_vec, '0);
        repeat (2) @(negedge clk);
        check("rst_mid_held", dut_vec, '0);
        rst = 1'b0;
        count_done(30, nd);
        check("rst_mid_no_done", nd, 0);

        // Zero-gap instance: lose melody plays back to back.
        bus_b.req = 3'b010;
        @(negedge clk);
        bus_b.req = 3'b000;
        check("gap0_grant", bus_b.grant, 3'b010);
        for (int k = 0; k < 24; k++) begin
            check("gap0_en", bus_b.tone_en, 1'b1);
            check("gap0_div", bus_b.tone_div, (k < 8) ? 41666 : 55555);
            @(negedge clk);
        end
        check("gap0_done", bus_b.done, 1'b1);
        check("gap0_idle_en", bus_b.tone_en, 1'b0);

        // Random traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            bus_a.req  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            bus_a.stop = ($urandom_range(0, 59) == 0);
            rst        = ($urandom_range(0, 399) == 0);
            @(negedge clk);
        end
        bus_a.req = 3'b000;
        bus_a.stop = 1'b0;
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("final_idle_busy", bus_a.busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
